pmp_csr_file: RTL and testbench
===============================

PMP_CSR_FILE -- requirements
Module: pmp_csr_file

Interface
REQ-001 SHALL have parameter NR_PMP_ENTRIES, default 8, number of implemented PMP entries (legal 1..16).
REQ-002 SHALL have parameter PMP_GRAN, default 0, granularity G (legal 0..30).
REQ-003 SHALL have port clk_i  input  1  clock.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid_i  input  1  CSR request valid.
REQ-006 SHALL have port req_ready_o  output  1  request accepted when valid&ready.
REQ-007 SHALL have port req_op_i  input  8  op: 31 write, 32 read, 33 set, 34 clear.
REQ-008 SHALL have port req_addr_i  input  12  CSR address.
REQ-009 SHALL have port req_wdata_i  input  32  write/set/clear operand.
REQ-010 SHALL have port rsp_valid_o  output  1  one-cycle response strobe.
REQ-011 SHALL have port rsp_rdata_o  output  32  pre-operation CSR value.
REQ-012 SHALL have port rsp_err_o  output  1  illegal op or unsupported address.
REQ-013 SHALL have port flush_req_o  output  1  PMP state changed; downstream flush request.
REQ-014 SHALL have port flush_ack_i  input  1  flush completed.
REQ-015 SHALL have ports pmpcfg_o  output  128 and pmpaddr_o  output  512, registered PMP state, entry i at byte i / word i.

Function
REQ-016 SHALL implement FSM IDLE -> RESP on accept; RESP -> FLUSH if stored state changed, else IDLE; FLUSH -> IDLE on flush_ack_i=1.
REQ-017 req_ready_o SHALL be 1 only in IDLE; rsp_valid_o SHALL be 1 only in RESP (latency exactly 1 cycle after accept); flush_req_o SHALL be 1 only in FLUSH.
REQ-018 rsp_rdata_o SHALL hold the value read before the operation; pmpcfg_o/pmpaddr_o SHALL show the updated value in the RESP cycle.
REQ-019 Addresses 0x3A0-0x3A3 (pmpcfg0-3) and 0x3B0-0x3BF (pmpaddr0-15) SHALL be supported; any other address or op SHALL set rsp_err_o=1, rdata 0, no state change.
REQ-020 Write value SHALL be wdata (31), old|wdata (33), old&~wdata (34); op 32, and ops 33/34 with wdata=0, SHALL perform no write.
REQ-021 pmpcfg byte write SHALL be skipped if old byte bit7 (L)=1 or entry index >= NR_PMP_ENTRIES (reads 0).
REQ-022 pmpcfg byte with new R=0,W=1, or with A=NA4 (2'b10) when G>=1, SHALL retain its old value; bits 6:5 SHALL always store 0.
REQ-023 pmpaddr[i] write SHALL be skipped if cfg[i].L=1, or if i+1<NR and cfg[i+1].L=1 with cfg[i+1].A=TOR (2'b01), or if i>=NR (reads 0).
REQ-024 pmpaddr read with G>=2 and A=NAPOT SHALL return bits G-2:0 as ones; with G>=1 and A=OFF/TOR SHALL return bits G-1:0 as zero; storage SHALL stay full width.
REQ-025 "Changed" SHALL mean any stored cfg/addr bit differs after the write; a fully skipped write SHALL not enter FLUSH.
REQ-026 flush_ack_i outside FLUSH SHALL be ignored; req_valid_i outside IDLE SHALL be ignored.

Reset
REQ-027 On rst_ni=0 all pmpcfg/pmpaddr SHALL be 0, FSM IDLE, rsp_valid_o=0, rsp_err_o=0, rsp_rdata_o=0, flush_req_o=0, req_ready_o=1.
REQ-028 Reset asserted mid-RESP or mid-FLUSH SHALL abort immediately with no pending response or flush.

Structure
REQ-029 Package pmp_csr_pkg SHALL hold op codes, CSR base addresses, A-field encodings (OFF/TOR/NA4/NAPOT) and the FSM state type.
REQ-030 Per-byte cfg legalisation SHALL be one combinational sub-module pmp_cfg_legalize, instantiated per entry.

Verification
REQ-031 Write 0x3A0=0x0000_001F, ack flush after 2 cycles -> rsp 1 cycle after accept, rdata 0, pmpcfg_o[7:0]=0x1F, flush_req 2 cycles then ready.
REQ-032 Set cfg0 byte0 L (0x80) then write pmpaddr0=0x1234 and pmpcfg0=0 -> both unchanged, no FLUSH entered.
REQ-033 cfg1=0x88 (L,TOR), write pmpaddr0=0xABCD -> pmpaddr0 unchanged; pmpaddr1 writable while cfg1 unlocked.
REQ-034 Write cfg byte 0x02 (W only) and, with NR=4, write 0x3A1 -> bytes retain 0 / read 0, no flush.
REQ-035 Op 33 wdata 0x01 on 0x3A0 then op 34 wdata 0x01 -> 0x01 then 0x00, rdata returns prior values; op 7 or addr 0x300 -> rsp_err_o=1.
REQ-036 Assert rst_ni in FLUSH -> flush_req_o=0, all outputs 0, req_ready_o=1 during reset.

Source files
------------

// File: rtl/pmp_csr_pkg.sv
// Shared definitions for the PMP CSR file: op codes, CSR bases, A-field
// encodings, FSM state type and a mask helper.
package pmp_csr_pkg;

  localparam logic [7:0] OP_WRITE = 8'd31;
  localparam logic [7:0] OP_READ  = 8'd32;
  localparam logic [7:0] OP_SET   = 8'd33;
  localparam logic [7:0] OP_CLEAR = 8'd34;

  localparam logic [11:0] CSR_PMPCFG0  = 12'h3A0;
  localparam logic [11:0] CSR_PMPADDR0 = 12'h3B0;

  localparam int MAX_PMP_ENTRIES = 16;

  typedef enum logic [1:0] {
    A_OFF   = 2'b00,
    A_TOR   = 2'b01,
    A_NA4   = 2'b10,
    A_NAPOT = 2'b11
  } pmp_a_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RESP  = 2'b01,
    ST_FLUSH = 2'b10
  } csr_state_e;

  // Mask with the lowest n bits set; n <= 0 yields zero.
  function automatic logic [31:0] low_ones(int n);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 32; b++) begin
      if (b < n) m[b] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/pmp_cfg_legalize.sv
// Legalises one pmpcfg byte: keeps the old byte when locked, not written,
// or when the new encoding is reserved; otherwise stores it with bits 6:5 cleared.
module pmp_cfg_legalize
  import pmp_csr_pkg::*;
#(
  parameter int PMP_GRAN = 0
) (
  input  logic       wr_en,
  input  logic [7:0] cfg_old,
  input  logic [7:0] cfg_wr,
  output logic [7:0] cfg_new
);

  logic w_without_r;
  logic na4_illegal;

  always_comb begin
    w_without_r = cfg_wr[1] & ~cfg_wr[0];
    na4_illegal = (PMP_GRAN >= 1) && (cfg_wr[4:3] == A_NA4);
    cfg_new     = cfg_old;
    if (wr_en && !cfg_old[7] && !w_without_r && !na4_illegal) begin
      cfg_new = {cfg_wr[7], 2'b00, cfg_wr[4:0]};
    end
  end

endmodule

// File: rtl/pmp_csr_file.sv
// PMP configuration/address CSR file with a request/response handshake and
// a flush request whenever the stored PMP state actually changes.
//
// state    | meaning
// ST_IDLE  | ready for a CSR request
// ST_RESP  | one-cycle response strobe, new state already visible
// ST_FLUSH | stored state changed, waiting for flush_ack_i
module pmp_csr_file
  import pmp_csr_pkg::*;
#(
  parameter int NR_PMP_ENTRIES = 8,
  parameter int PMP_GRAN       = 0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         req_valid_i,
  output logic         req_ready_o,
  input  logic [7:0]   req_op_i,
  input  logic [11:0]  req_addr_i,
  input  logic [31:0]  req_wdata_i,
  output logic         rsp_valid_o,
  output logic [31:0]  rsp_rdata_o,
  output logic         rsp_err_o,
  output logic         flush_req_o,
  input  logic         flush_ack_i,
  output logic [127:0] pmpcfg_o,
  output logic [511:0] pmpaddr_o
);

  localparam logic [31:0] NAPOT_ONES = low_ones(PMP_GRAN - 1);
  localparam logic [31:0] GRAN_MASK  = low_ones(PMP_GRAN);

  csr_state_e state_q, state_d;

  logic [MAX_PMP_ENTRIES-1:0][7:0]  cfg_q, cfg_d;
  logic [MAX_PMP_ENTRIES-1:0][31:0] addr_q, addr_d;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        changed_q;

  logic        accept;
  logic        is_cfg, is_addr, op_legal, csr_ok, do_write, changed;
  logic [1:0]  cfg_sel;
  logic [3:0]  addr_sel;
  logic [1:0]  sel_a;
  logic [31:0] cfg_word, addr_word, old_val, new_val;

  assign accept   = (state_q == ST_IDLE) && req_valid_i;
  assign is_cfg   = (req_addr_i[11:2] == CSR_PMPCFG0[11:2]);
  assign is_addr  = (req_addr_i[11:4] == CSR_PMPADDR0[11:4]);
  assign cfg_sel  = req_addr_i[1:0];
  assign addr_sel = req_addr_i[3:0];
  assign op_legal = req_op_i inside {OP_WRITE, OP_READ, OP_SET, OP_CLEAR};
  assign csr_ok   = op_legal && (is_cfg || is_addr);

  // Read view of the addressed CSR; pmpaddr low bits follow the granularity.
  always_comb begin
    cfg_word  = cfg_q[{cfg_sel, 2'b00} +: 4];
    sel_a     = cfg_q[addr_sel][4:3];
    addr_word = addr_q[addr_sel];
    if (sel_a == A_NAPOT) begin
      addr_word = addr_word | NAPOT_ONES;
    end else if (sel_a == A_OFF || sel_a == A_TOR) begin
      addr_word = addr_word & ~GRAN_MASK;
    end
    old_val = '0;
    if (csr_ok) old_val = is_cfg ? cfg_word : addr_word;
  end

  always_comb begin
    new_val  = old_val;
    do_write = 1'b0;
    if (csr_ok) begin
      unique case (req_op_i)
        OP_WRITE: begin
          new_val  = req_wdata_i;
          do_write = 1'b1;
        end
        OP_SET: begin
          new_val  = old_val | req_wdata_i;
          do_write = (req_wdata_i != '0);
        end
        OP_CLEAR: begin
          new_val  = old_val & ~req_wdata_i;
          do_write = (req_wdata_i != '0);
        end
        default: begin
          new_val  = old_val;
          do_write = 1'b0;
        end
      endcase
    end
  end

  for (genvar i = 0; i < MAX_PMP_ENTRIES; i++) begin : g_entry
    if (i < NR_PMP_ENTRIES) begin : g_impl
      logic cfg_we;
      logic next_tor_lock;
      logic addr_lock;

      assign cfg_we = do_write && is_cfg && (cfg_sel == 2'(i / 4));

      pmp_cfg_legalize #(
        .PMP_GRAN(PMP_GRAN)
      ) u_legalize (
        .wr_en  (cfg_we),
        .cfg_old(cfg_q[i]),
        .cfg_wr (new_val[8*(i%4) +: 8]),
        .cfg_new(cfg_d[i])
      );

      // A locked TOR entry above also protects this entry's address.
      if (i + 1 < NR_PMP_ENTRIES) begin : g_tor
        assign next_tor_lock = cfg_q[i+1][7] && (cfg_q[i+1][4:3] == A_TOR);
      end else begin : g_last
        assign next_tor_lock = 1'b0;
      end

      assign addr_lock = cfg_q[i][7] || next_tor_lock;
      assign addr_d[i] = (do_write && is_addr && (addr_sel == 4'(i)) && !addr_lock)
                         ? new_val : addr_q[i];
    end else begin : g_unimpl
      assign cfg_d[i]  = '0;
      assign addr_d[i] = '0;
    end
  end

  assign changed = (cfg_d != cfg_q) || (addr_d != addr_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      cfg_q     <= '0;
      addr_q    <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cfg_q     <= cfg_d;
        addr_q    <= addr_d;
        rdata_q   <= old_val;
        err_q     <= !csr_ok;
        changed_q <= changed;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    rsp_rdata_o = '0;
    rsp_err_o   = 1'b0;
    flush_req_o = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) state_d = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid_o = 1'b1;
        rsp_rdata_o = rdata_q;
        rsp_err_o   = err_q;
        state_d     = changed_q ? ST_FLUSH : ST_IDLE;
      end
      ST_FLUSH: begin
        flush_req_o = 1'b1;
        if (flush_ack_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign pmpcfg_o  = cfg_q;
  assign pmpaddr_o = addr_q;

endmodule

// File: tb/tb_pmp_csr_file.sv
// Randomised bench for pmp_csr_file against a behavioural model of the PMP
// CSR rules (NR=4 entries, granularity 2).
module tb_pmp_csr_file;

  localparam int NR = 4;
  localparam int G  = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic [7:0]   req_op;
  logic [11:0]  req_addr;
  logic [31:0]  req_wdata;
  logic         rsp_valid;
  logic [31:0]  rsp_rdata;
  logic         rsp_err;
  logic         flush_req;
  logic         flush_ack;
  logic [127:0] pmpcfg;
  logic [511:0] pmpaddr;

  int total = 0;
  int bad   = 0;

  byte unsigned m_cfg[16];
  int unsigned  m_addr[16];

  always #5 clk = ~clk;

  pmp_csr_file #(
    .NR_PMP_ENTRIES(NR),
    .PMP_GRAN      (G)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_op_i   (req_op),
    .req_addr_i (req_addr),
    .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid),
    .rsp_rdata_o(rsp_rdata),
    .rsp_err_o  (rsp_err),
    .flush_req_o(flush_req),
    .flush_ack_i(flush_ack),
    .pmpcfg_o   (pmpcfg),
    .pmpaddr_o  (pmpaddr)
  );

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] exp_cfg_vec();
    logic [127:0] v;
    for (int i = 0; i < 16; i++) v[8*i +: 8] = m_cfg[i];
    return v;
  endfunction

  function automatic logic [511:0] exp_addr_vec();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[32*i +: 32] = m_addr[i];
    return v;
  endfunction

  function automatic int unsigned m_read_addr(int n);
    int unsigned v;
    int a;
    if (n >= NR) return 0;
    v = m_addr[n];
    a = (int'(m_cfg[n]) >> 3) & 3;
    if (G >= 2 && a == 3) v = v | ((32'd1 << (G - 1)) - 32'd1);
    if (G >= 1 && a <= 1) v = v & ~((32'd1 << G) - 32'd1);
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_cfg[i]  = 0;
      m_addr[i] = 0;
    end
  endtask

  task automatic model_op(input int op, input int addr, input int unsigned wd,
                          output int unsigned rdata, output bit err, output bit chg);
    bit is_cfg, is_addr, wr, lock;
    int n, e, b;
    int unsigned old, nv;
    byte unsigned pc[16];
    int unsigned  pa[16];
    for (int i = 0; i < 16; i++) begin
      pc[i] = m_cfg[i];
      pa[i] = m_addr[i];
    end
    is_cfg  = (addr >= 'h3A0) && (addr <= 'h3A3);
    is_addr = (addr >= 'h3B0) && (addr <= 'h3BF);
    rdata = 0;
    err   = 0;
    chg   = 0;
    if (!(op >= 31 && op <= 34) || !(is_cfg || is_addr)) begin
      err = 1;
      return;
    end
    old = 0;
    if (is_cfg) begin
      n = addr - 'h3A0;
      for (int k = 0; k < 4; k++) old = old | (int'(m_cfg[4*n+k]) << (8*k));
    end else begin
      n = addr - 'h3B0;
      old = m_read_addr(n);
    end
    rdata = old;
    case (op)
      31:      nv = wd;
      33:      nv = old | wd;
      34:      nv = old & ~wd;
      default: nv = old;
    endcase
    wr = (op == 31) || ((op == 33 || op == 34) && wd != 0);
    if (wr && is_cfg) begin
      for (int k = 0; k < 4; k++) begin
        e = 4*n + k;
        b = int'((nv >> (8*k)) & 32'hFF);
        if (e < NR && (pc[e] & 8'h80) == 0 && (b & 3) != 2 &&
            !(G >= 1 && ((b >> 3) & 3) == 2))
          m_cfg[e] = byte'(b & 'h9F);
      end
    end
    if (wr && is_addr) begin
      lock = (n >= NR) || ((pc[n] & 8'h80) != 0);
      if (n + 1 < NR && (pc[n+1] & 8'h80) != 0 && ((int'(pc[n+1]) >> 3) & 3) == 1) lock = 1;
      if (!lock) m_addr[n] = nv;
    end
    for (int i = 0; i < 16; i++) begin
      if (m_cfg[i] != pc[i] || m_addr[i] != pa[i]) chg = 1;
    end
  endtask

  // One transaction: issue, check the response cycle, then flush or idle.
  task automatic do_op(input int op, input int addr, input int unsigned wd,
                       input int ack_dly, input string tag);
    int unsigned er;
    bit ee, ec;
    int fl;
    @(negedge clk);
    check({tag, "/ready"}, req_ready, 1);
    req_valid = 1'b1;
    req_op    = op[7:0];
    req_addr  = addr[11:0];
    req_wdata = wd;
    model_op(op, addr, wd, er, ee, ec);
    @(negedge clk);
    req_valid = 1'($urandom_range(0, 1));
    req_op    = 8'd31;
    req_addr  = 12'h3B0;
    req_wdata = $urandom;
    flush_ack = 1'($urandom_range(0, 1));
    check({tag, "/rsp_valid"}, rsp_valid, 1);
    check({tag, "/rdata"}, rsp_rdata, er);
    check({tag, "/err"}, rsp_err, ee);
    check({tag, "/cfg"}, pmpcfg, exp_cfg_vec());
    check({tag, "/addr"}, pmpaddr, exp_addr_vec());
    check({tag, "/ready_resp"}, req_ready, 0);
    @(negedge clk);
    req_valid = 1'b0;
    flush_ack = 1'b0;
    check({tag, "/rsp_off"}, rsp_valid, 0);
    if (ec) begin
      fl = 0;
      while (flush_req === 1'b1 && fl < 20) begin
        fl++;
        if (fl == ack_dly) flush_ack = 1'b1;
        @(negedge clk);
        flush_ack = 1'b0;
      end
      check({tag, "/flush_cycles"}, fl, ack_dly);
    end else begin
      check({tag, "/no_flush"}, flush_req, 0);
    end
    check({tag, "/ready_after"}, req_ready, 1);
    check({tag, "/cfg_after"}, pmpcfg, exp_cfg_vec());
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "/ready"}, req_ready, 1);
    check({tag, "/rsp_valid"}, rsp_valid, 0);
    check({tag, "/err"}, rsp_err, 0);
    check({tag, "/rdata"}, rsp_rdata, 0);
    check({tag, "/flush"}, flush_req, 0);
    check({tag, "/cfg"}, pmpcfg, 0);
    check({tag, "/addr"}, pmpaddr, 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int op, addr, sel;
  int unsigned wd;

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_op    = '0;
    req_addr  = '0;
    req_wdata = '0;
    flush_ack = 1'b0;
    model_reset();
    #12;
    check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;

    do_op(31, 'h3A0, 32'h0000_001F, 2, "wr_cfg0");
    check("cfg0_byte", pmpcfg[7:0], 8'h1F);

    do_op(31, 'h3A0, 32'h0, 1, "clr_cfg0");
    do_op(33, 'h3A0, 32'h01, 1, "set_bit");
    check("set_val", pmpcfg[7:0], 8'h01);
    do_op(34, 'h3A0, 32'h01, 1, "clear_bit");
    check("clear_val", pmpcfg[7:0], 8'h00);
    do_op(7, 'h3A0, 32'h01, 1, "bad_op");
    do_op(32, 'h300, 32'h0, 1, "bad_addr");

    do_op(31, 'h3A0, 32'h0000_0002, 1, "w_only");
    do_op(31, 'h3A1, 32'h0F0F_0F0F, 1, "cfg_unimpl");
    do_op(32, 'h3A1, 32'h0, 1, "rd_unimpl");

    do_op(31, 'h3B2, 32'hFFFF_FFFF, 3, "addr2_ones");
    do_op(32, 'h3B2, 32'h0, 1, "addr2_off_rd");
    do_op(31, 'h3B3, 32'h0000_0100, 1, "addr3");
    do_op(31, 'h3A0, 32'h1800_0000, 1, "cfg3_napot");
    do_op(32, 'h3B3, 32'h0, 1, "addr3_napot_rd");

    do_op(31, 'h3B1, 32'h0000_5555, 2, "addr1_open");
    do_op(31, 'h3A0, 32'h0000_8800, 1, "cfg1_lock_tor");
    do_op(31, 'h3B0, 32'h0000_ABCD, 1, "addr0_tor_lock");
    do_op(31, 'h3B1, 32'h0000_1111, 1, "addr1_locked");
    do_op(33, 'h3A0, 32'h0000_0080, 1, "cfg0_lock");
    do_op(31, 'h3B0, 32'h0000_1234, 1, "addr0_locked");
    do_op(31, 'h3A0, 32'h0, 1, "cfg0_locked");

    pulse_reset();

    for (int t = 0; t < 300; t++) begin
      if (t % 60 == 59) pulse_reset();
      sel = $urandom_range(0, 9);
      op  = (sel == 0) ? 7 : 31 + $urandom_range(0, 3);
      sel = $urandom_range(0, 19);
      if (sel < 9)       addr = 'h3A0 + $urandom_range(0, 3);
      else if (sel < 18) addr = 'h3B0 + $urandom_range(0, 15);
      else if (sel < 19) addr = 'h300;
      else               addr = 'h3A4;
      wd = $urandom;
      if (addr >= 'h3A0 && addr <= 'h3A3) begin
        wd = wd & 32'h7F7F_7F7F;
        if ($urandom_range(0, 15) == 0) wd = wd | (32'h80 << (8 * $urandom_range(0, 3)));
      end
      if ($urandom_range(0, 9) == 0) wd = 0;
      do_op(op, addr, wd, $urandom_range(1, 3), "rand");
    end

    pulse_reset();
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 8'd31;
    req_addr  = 12'h3B0;
    req_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_flush", flush_req, 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_in_flush");
    @(negedge clk);
    check("rst_hold_flush", flush_req, 0);
    check("rst_hold_ready", req_ready, 1);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    check("post_rst_idle", flush_req, 0);
    do_op(32, 'h3B0, 32'h0, 1, "post_rst_rd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
